// File: rtl/icache_fetch_pkg.sv
// Shared constants for the instruction-fetch cache: bus widths, line geometry,
// fill word and FSM state encodings.
package icache_fetch_pkg;

    localparam int PC_W        = 64;
    localparam int LINE_BYTES  = 16;
    localparam int OFFSET_W    = 4;
    localparam int LINE_W      = LINE_BYTES * 8;
    localparam int LINE_ADDR_W = PC_W - OFFSET_W;
    localparam int LANES       = 4;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // A lane count of 0 or anything above 4 means a full bundle.
    function automatic logic [2:0] norm_count(input logic [2:0] cnt);
        return (cnt == 3'd0 || cnt > 3'd4) ? 3'd4 : cnt;
    endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-side bus (PC stage <-> cache) and memory-side bus (cache <-> line memory).
interface icache_fetch_if;
    import icache_fetch_pkg::*;

    logic [PC_W-1:0]   pc;
    logic [2:0]        pc_counter;
    logic              pc_valid;
    logic              flush;
    logic [LINE_W-1:0] inst_i;
    logic              cache_un_ready;

    modport master (output pc, pc_counter, pc_valid, flush,
                    input  inst_i, cache_un_ready);
    modport slave  (input  pc, pc_counter, pc_valid, flush,
                    output inst_i, cache_un_ready);
endinterface

interface icache_mem_if;
    import icache_fetch_pkg::*;

    logic              mem_req;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [LINE_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr,
                    input  mem_ack, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_addr,
                    output mem_ack, mem_rvalid, mem_rdata);
endinterface

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: per-line valid flops plus tag/data arrays,
// one combinational read port, one write port and a bulk valid clear.
module icache_line_array
    import icache_fetch_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = LINE_ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              clr_all
);
    logic [LINES-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    // Clear takes priority over a same-cycle validate.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (!rst || clr_all)
                valid_reg[gi] <= 1'b0;
            else if (we && wr_idx == IDX_W'(gi))
                valid_reg[gi] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// Read-only direct-mapped instruction cache with a zero-latency hit path and a
// three-state (IDLE/REQ/WAIT) line refill engine.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int          LINES    = 8,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    icache_fetch_if.slave fetch,
    icache_mem_if.master  mem
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = LINE_ADDR_W - IDX_W;

    logic [1:0]             state_reg;
    logic [LINE_ADDR_W-1:0] miss_addr_reg;
    logic                   mem_req_reg;
    logic [PC_W-1:0]        mem_addr_reg;
    logic                   flush_pend_reg;

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic [LINE_W-1:0] rd_data;
    logic              hit;
    logic              line_we;
    logic [2:0]        lane_cnt;
    logic [31:0]       lane_word [LANES];
    logic              unused_pc_lsb;

    assign rd_idx        = fetch.pc[OFFSET_W +: IDX_W];
    assign pc_tag        = fetch.pc[PC_W-1 : OFFSET_W+IDX_W];
    assign unused_pc_lsb = ^fetch.pc[1:0];

    // A flushing cycle never reports a hit, so the PC stage holds.
    assign hit = fetch.pc_valid && !fetch.flush && rd_valid
              && (rd_tag == pc_tag) && (state_reg == ST_IDLE);

    // Data returned after a flush (this cycle or earlier in the refill) is dropped.
    assign line_we = (state_reg == ST_WAIT) && mem.mem_rvalid
                  && !flush_pend_reg && !fetch.flush;

    icache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (line_we),
        .wr_idx   (miss_addr_reg[IDX_W-1:0]),
        .wr_tag   (miss_addr_reg[LINE_ADDR_W-1:IDX_W]),
        .wr_data  (mem.mem_rdata),
        .clr_all  (fetch.flush)
    );

    assign lane_cnt = norm_count(fetch.pc_counter);

    // Lane k takes line word pc[3:2]+k; lanes past the line end or the count get NOP.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [2:0] word_pos;
        assign word_pos      = {1'b0, fetch.pc[3:2]} + 3'(gi);
        assign lane_word[gi] = (hit && !word_pos[2] && (3'(gi) < lane_cnt))
                             ? rd_data[32*word_pos[1:0] +: 32] : NOP_WORD;
    end

    assign fetch.inst_i         = {lane_word[3], lane_word[2], lane_word[1], lane_word[0]};
    assign fetch.cache_un_ready = !hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            miss_addr_reg  <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fetch.pc_valid && !fetch.flush && !hit) begin
                        state_reg     <= ST_REQ;
                        miss_addr_reg <= fetch.pc[PC_W-1:OFFSET_W];
                        mem_req_reg   <= 1'b1;
                        mem_addr_reg  <= {fetch.pc[PC_W-1:OFFSET_W], 4'b0000};
                    end
                end
                ST_REQ: begin
                    if (fetch.flush)
                        flush_pend_reg <= 1'b1;
                    if (mem.mem_ack) begin
                        state_reg   <= ST_WAIT;
                        mem_req_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid) begin
                        state_reg      <= ST_IDLE;
                        flush_pend_reg <= 1'b0;
                    end else if (fetch.flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_reg;
    assign mem.mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: table of hit lookups plus hand-written
// refill, eviction, stall, flush and reset sequences.
module tb_icache_fetch;

    localparam logic [31:0] N  = 32'h0000_0013;
    localparam logic [31:0] WA = 32'hA0A0_A0A0, WB = 32'hB1B1_B1B1,
                            WC = 32'hC2C2_C2C2, WD = 32'hD3D3_D3D3;
    localparam logic [31:0] WE = 32'hE4E4_E4E4, WF = 32'hF5F5_F5F5,
                            WG = 32'h1616_1616, WH = 32'h2727_2727;
    localparam logic [31:0] WI = 32'h3838_3838, WJ = 32'h4949_4949,
                            WK = 32'h5A5A_5A5A, WL = 32'h6B6B_6B6B;
    localparam logic [127:0] NOPS = {N, N, N, N};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    icache_fetch_if fif ();
    icache_mem_if   mif ();

    icache_fetch #(.LINES(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (fif),
        .mem   (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  pc;
        logic [2:0]   cnt;
        logic         valid;
        logic         exp_unready;
        logic [127:0] exp_inst;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic drive_pc(input logic [63:0] pc, input logic [2:0] cnt, input logic v);
        fif.pc         = pc;
        fif.pc_counter = cnt;
        fif.pc_valid   = v;
    endtask

    // Waits (bounded) for a request, checks its address, then acks and returns data.
    task automatic refill(input string name, input logic [63:0] exp_addr, input logic [127:0] data);
        int n;
        n = 0;
        while (!mif.mem_req && n < 20) begin
            step();
            n++;
        end
        chk({name, " mem_req"}, 128'(mif.mem_req), 128'd1);
        chk({name, " mem_addr"}, 128'(mif.mem_addr), 128'(exp_addr));
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack    = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = data;
        step();
        mif.mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h8000_0000, 3'd4, 1'b1, 1'b0, {WD, WC, WB, WA}};
        vecs[1] = '{64'h8000_0008, 3'd2, 1'b1, 1'b0, {N,  N,  WD, WC}};
        vecs[2] = '{64'h8000_0004, 3'd4, 1'b1, 1'b0, {N,  WD, WC, WB}};
        vecs[3] = '{64'h8000_000C, 3'd1, 1'b1, 1'b0, {N,  N,  N,  WD}};
        vecs[4] = '{64'h8000_0000, 3'd0, 1'b1, 1'b0, {WD, WC, WB, WA}};
        vecs[5] = '{64'h8000_0000, 3'd7, 1'b1, 1'b0, {WD, WC, WB, WA}};
        vecs[6] = '{64'h8000_0004, 3'd2, 1'b1, 1'b0, {N,  N,  WC, WB}};
        vecs[7] = '{64'h8000_0002, 3'd3, 1'b1, 1'b0, {N,  WC, WB, WA}};
        vecs[8] = '{64'h8000_0008, 3'd0, 1'b1, 1'b0, {N,  N,  WD, WC}};
        vecs[9] = '{64'h8000_0000, 3'd4, 1'b0, 1'b1, NOPS};

        drive_pc(64'h0, 3'd0, 1'b0);
        fif.flush      = 1'b0;
        mif.mem_ack    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;

        // Reset state
        repeat (3) step();
        drive_pc(64'h8000_0000, 3'd4, 1'b1);
        #2;
        chk("reset un_ready", 128'(fif.cache_un_ready), 128'd1);
        chk("reset inst", fif.inst_i, NOPS);
        chk("reset mem_req", 128'(mif.mem_req), 128'd0);
        chk("reset mem_addr", 128'(mif.mem_addr), 128'd0);
        step();
        rst = 1'b1;

        // First miss and refill
        #2;
        chk("miss un_ready", 128'(fif.cache_un_ready), 128'd1);
        chk("miss inst", fif.inst_i, NOPS);
        refill("fill0", 64'h8000_0000, {WD, WC, WB, WA});
        #2;
        chk("fill0 un_ready", 128'(fif.cache_un_ready), 128'd0);
        chk("fill0 inst", fif.inst_i, {WD, WC, WB, WA});

        // Hit lookups
        for (int i = 0; i < 10; i++) begin
            step();
            drive_pc(vecs[i].pc, vecs[i].cnt, vecs[i].valid);
            #2;
            chk($sformatf("vec%0d un_ready", i), 128'(fif.cache_un_ready), 128'(vecs[i].exp_unready));
            chk($sformatf("vec%0d inst", i), fif.inst_i, vecs[i].exp_inst);
        end

        // Conflict miss replaces the line, original address then misses
        step();
        drive_pc(64'h8000_0080, 3'd4, 1'b1);
        #2;
        chk("conflict miss", 128'(fif.cache_un_ready), 128'd1);
        refill("fill1", 64'h8000_0080, {WH, WG, WF, WE});
        #2;
        chk("fill1 inst", fif.inst_i, {WH, WG, WF, WE});
        step();
        drive_pc(64'h8000_0000, 3'd4, 1'b1);
        #2;
        chk("evicted miss", 128'(fif.cache_un_ready), 128'd1);

        // Ack withheld for 5 cycles while pc moves on
        step();
        drive_pc(64'h8000_0010, 3'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d mem_req", i), 128'(mif.mem_req), 128'd1);
            chk($sformatf("stall%0d mem_addr", i), 128'(mif.mem_addr), 128'h8000_0000);
            step();
        end
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack    = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = {WD, WC, WB, WA};
        step();
        mif.mem_rvalid = 1'b0;
        #2;
        chk("new pc miss", 128'(fif.cache_un_ready), 128'd1);
        chk("post-ack mem_req", 128'(mif.mem_req), 128'd0);
        refill("fill2", 64'h8000_0010, {WL, WK, WJ, WI});
        #2;
        chk("fill2 inst", fif.inst_i, {WL, WK, WJ, WI});
        step();
        drive_pc(64'h8000_0000, 3'd4, 1'b1);
        #2;
        chk("stalled fill kept", fif.inst_i, {WD, WC, WB, WA});

        // Flush in IDLE
        fif.flush = 1'b1;
        #1;
        chk("flush un_ready", 128'(fif.cache_un_ready), 128'd1);
        step();
        fif.flush = 1'b0;
        chk("flush no req", 128'(mif.mem_req), 128'd0);
        #2;
        chk("after flush miss", 128'(fif.cache_un_ready), 128'd1);

        // Flush while waiting for data: line stays invalid and is re-requested
        step();
        chk("wflush mem_req", 128'(mif.mem_req), 128'd1);
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        fif.flush   = 1'b1;
        step();
        fif.flush      = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = {WD, WC, WB, WA};
        step();
        mif.mem_rvalid = 1'b0;
        #2;
        chk("wflush still miss", 128'(fif.cache_un_ready), 128'd1);
        refill("refetch", 64'h8000_0000, {WD, WC, WB, WA});
        #2;
        chk("refetch inst", fif.inst_i, {WD, WC, WB, WA});

        // Reset during WAIT abandons the refill; a late rvalid is ignored
        step();
        drive_pc(64'h8000_0020, 3'd4, 1'b1);
        step();
        chk("rst-seq mem_req", 128'(mif.mem_req), 128'd1);
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        rst         = 1'b0;
        step();
        rst            = 1'b1;
        fif.pc_valid   = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = {WH, WG, WF, WE};
        #2;
        chk("rst-seq mem_req low", 128'(mif.mem_req), 128'd0);
        chk("rst-seq un_ready", 128'(fif.cache_un_ready), 128'd1);
        step();
        mif.mem_rvalid = 1'b0;
        drive_pc(64'h8000_0020, 3'd4, 1'b1);
        #2;
        chk("late rvalid ignored", 128'(fif.cache_un_ready), 128'd1);
        chk("late rvalid inst", fif.inst_i, NOPS);
        step();
        chk("rst-seq re-req", 128'(mif.mem_req), 128'd1);
        chk("rst-seq re-addr", 128'(mif.mem_addr), 128'h8000_0020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
